// File: rtl/lsu_ctrl_pkg.sv
// Shared constants for the load/store unit: RISC-V opcodes, funct3 codes
// and the controller state encoding.
package lsu_ctrl_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath for the LSU: decode/legality, store lane replication
// and byte mask, and load byte/half extraction with sign or zero extension.
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic        is_load,
  output logic        legal,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wmask,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  always_comb begin
    is_load = (opcode == OP_LOAD);
    legal   = 1'b0;
    if (opcode == OP_LOAD) begin
      case (funct3)
        F3_B, F3_BU: legal = 1'b1;
        F3_H, F3_HU: legal = ~addr_lo[0];
        F3_W:        legal = (addr_lo == 2'b00);
        default:     legal = 1'b0;
      endcase
    end else if (opcode == OP_STORE) begin
      case (funct3)
        F3_B:    legal = 1'b1;
        F3_H:    legal = ~addr_lo[0];
        F3_W:    legal = (addr_lo == 2'b00);
        default: legal = 1'b0;
      endcase
    end
  end

  // Only funct3[1:0] selects the size; illegal codes never reach memory.
  always_comb begin
    st_wdata = wdata;
    st_wmask = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{wdata[7:0]}};
        st_wmask = 4'b0001 << addr_lo;
      end
      2'b01: begin
        st_wdata = {2{wdata[15:0]}};
        st_wmask = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = wdata;
        st_wmask = 4'b1111;
      end
    endcase
  end

  always_comb begin
    byte_sh = mem_rdata >> {ld_addr_lo, 3'b000};
    half_sh = mem_rdata >> {ld_addr_lo[1], 4'b0000};
    case (ld_funct3)
      F3_B:    ld_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
      F3_BU:   ld_data = {24'h000000, byte_sh[7:0]};
      F3_H:    ld_data = {{16{half_sh[15]}}, half_sh[15:0]};
      F3_HU:   ld_data = {16'h0000, half_sh[15:0]};
      default: ld_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: accepts one op from execute, runs a single word
// access over the mem_req/mem_ready handshake and reports done/err/rdata.
//
// Handshake: mem_req rises the cycle after an accepted start and stays high,
// with mem_we/mem_addr/mem_wdata/mem_wmask stable, until a cycle in which
// mem_ready is high (transfer completes that cycle) or the timeout fires.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] inst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output lsu_state_e  dbg_state
);

  lsu_state_e  state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        is_load_q, is_load_d;

  logic        req_is_load;
  logic        req_legal;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic [31:0] ld_data;
  logic        unused_bits;

  assign unused_bits = ^{inst[31:15], inst[11:7], addr_lo_q[0] & 1'b0};

  lsu_align u_align (
    .opcode     (inst[6:0]),
    .funct3     (inst[14:12]),
    .addr_lo    (addr[1:0]),
    .wdata      (wdata),
    .is_load    (req_is_load),
    .legal      (req_legal),
    .st_wdata   (req_wdata),
    .st_wmask   (req_wmask),
    .ld_funct3  (f3_q),
    .ld_addr_lo (addr_lo_q),
    .mem_rdata  (mem_rdata),
    .ld_data    (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    cnt_d       = cnt_q;
    f3_d        = f3_q;
    addr_lo_d   = addr_lo_q;
    is_load_d   = is_load_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          f3_d      = inst[14:12];
          addr_lo_d = addr[1:0];
          is_load_d = req_is_load;
          busy_d    = 1'b1;
          cnt_d     = '0;
          if (req_legal) begin
            state_d     = ST_ACCESS;
            mem_req_d   = 1'b1;
            mem_we_d    = ~req_is_load;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_wdata_d = req_wdata;
            mem_wmask_d = req_is_load ? 4'b0000 : req_wmask;
          end else begin
            state_d = ST_RESP;
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      ST_ACCESS: begin
        // mem_ready is checked first so it beats a timeout in the same cycle.
        if (mem_ready) begin
          state_d   = ST_RESP;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b0;
          rdata_d   = is_load_q ? ld_data : 32'h0;
        end else if (TIMEOUT != 0 && cnt_q == TIMEOUT - 1) begin
          state_d   = ST_RESP;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b1;
          rdata_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        err_d   = 1'b0;
      end
      default: begin
        state_d   = ST_IDLE;
        busy_d    = 1'b0;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      cnt_q       <= '0;
      f3_q        <= '0;
      addr_lo_q   <= '0;
      is_load_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      cnt_q       <= cnt_d;
      f3_q        <= f3_d;
      addr_lo_q   <= addr_lo_d;
      is_load_q   <= is_load_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a table of single operations with hand-computed
// results, plus sequences for idle mem_ready, ignored start and mid-op reset.
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] inst = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  lsu_state_e  dbg_state;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  lsu_ctrl #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .inst      (inst),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdmem;
    int          waits;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_req;
    logic        exp_we;
    logic [3:0]  exp_mask;
    logic [31:0] exp_mwdata;
    logic [31:0] exp_maddr;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
    return {17'h0, f3, 5'h0, op};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver + memory responder for one op; lat counts edges from the start edge
  task automatic run_op(input vec_t v);
    int lat, req_cyc, wcnt;
    logic        c_we;
    logic [3:0]  c_mask;
    logic [31:0] c_wdata, c_addr;
    c_we = 1'b0; c_mask = '0; c_wdata = '0; c_addr = '0;
    @(negedge clk);
    start = 1'b1; inst = v.inst; addr = v.addr; wdata = v.wdata;
    tick();
    start = 1'b0;
    chk({v.name, " busy_after_start"}, 32'(busy), 32'd1);
    lat = 1; req_cyc = 0; wcnt = 0;
    while (!done && lat < 20) begin
      if (mem_req) begin
        if (req_cyc == 0) begin
          c_we = mem_we; c_mask = mem_wmask; c_wdata = mem_wdata; c_addr = mem_addr;
        end
        req_cyc++;
        if (wcnt == v.waits) begin
          mem_ready = 1'b1;
          mem_rdata = v.rdmem;
        end else begin
          mem_ready = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ready = 1'b0;
      end
      tick();
      lat++;
    end
    mem_ready = 1'b0;
    if (!done) begin
      tot_cnt++;
      $display("FAIL %s done_wait: got no done after %0d cycles, expected done", v.name, lat);
      return;
    end
    chk({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
    chk({v.name, " req_cycles"}, 32'(req_cyc), 32'(v.exp_req));
    chk({v.name, " err"}, 32'(err), 32'(v.exp_err));
    chk({v.name, " rdata"}, rdata, v.exp_rdata);
    chk({v.name, " busy_at_done"}, 32'(busy), 32'd1);
    if (v.exp_req > 0) begin
      chk({v.name, " mem_we"}, 32'(c_we), 32'(v.exp_we));
      chk({v.name, " mem_wmask"}, 32'(c_mask), 32'(v.exp_mask));
      chk({v.name, " mem_addr"}, c_addr, v.exp_maddr);
      if (v.exp_we) chk({v.name, " mem_wdata"}, c_wdata, v.exp_mwdata);
    end
    tick();
    chk({v.name, " done_one_cycle"}, 32'(done), 32'd0);
    chk({v.name, " busy_cleared"}, 32'(busy), 32'd0);
    chk({v.name, " rdata_held"}, rdata, v.exp_rdata);
  endtask

  initial begin : main
    vec_t v;
    int   cyc;
    logic saw_done;

    // name inst addr wdata rdmem waits err rdata lat req we mask mwdata maddr
    vecs.push_back('{"sw_zero_wait", mk(OP_STORE, F3_W), 32'h100, 32'hDEADBEEF, 32'h0, 0,
                     1'b0, 32'h0, 2, 1, 1'b1, 4'b1111, 32'hDEADBEEF, 32'h100});
    vecs.push_back('{"sb_lane3", mk(OP_STORE, F3_B), 32'h103, 32'h000000A5, 32'h0, 0,
                     1'b0, 32'h0, 2, 1, 1'b1, 4'b1000, 32'hA5A5A5A5, 32'h100});
    vecs.push_back('{"lb_sign", mk(OP_LOAD, F3_B), 32'h202, 32'h0, 32'h12807F34, 0,
                     1'b0, 32'hFFFFFF80, 2, 1, 1'b0, 4'b0000, 32'h0, 32'h200});
    vecs.push_back('{"lbu_1wait", mk(OP_LOAD, F3_BU), 32'h202, 32'h0, 32'h12807F34, 1,
                     1'b0, 32'h00000080, 3, 2, 1'b0, 4'b0000, 32'h0, 32'h200});
    vecs.push_back('{"lh_misalign", mk(OP_LOAD, F3_H), 32'h201, 32'h0, 32'h0, 0,
                     1'b1, 32'h0, 1, 0, 1'b0, 4'b0000, 32'h0, 32'h0});
    vecs.push_back('{"lw_timeout", mk(OP_LOAD, F3_W), 32'h400, 32'h0, 32'h11111111, 99,
                     1'b1, 32'h0, 5, 4, 1'b0, 4'b0000, 32'h0, 32'h400});
    vecs.push_back('{"lw_3waits", mk(OP_LOAD, F3_W), 32'h404, 32'h0, 32'hCAFEF00D, 3,
                     1'b0, 32'hCAFEF00D, 5, 4, 1'b0, 4'b0000, 32'h0, 32'h404});
    vecs.push_back('{"sh_upper", mk(OP_STORE, F3_H), 32'h102, 32'h1234ABCD, 32'h0, 0,
                     1'b0, 32'h0, 2, 1, 1'b1, 4'b1100, 32'hABCDABCD, 32'h100});
    vecs.push_back('{"lh_sign_hi", mk(OP_LOAD, F3_H), 32'h202, 32'h0, 32'h80017FFF, 0,
                     1'b0, 32'hFFFF8001, 2, 1, 1'b0, 4'b0000, 32'h0, 32'h200});
    vecs.push_back('{"lhu_lo", mk(OP_LOAD, F3_HU), 32'h200, 32'h0, 32'h80017FFF, 2,
                     1'b0, 32'h00007FFF, 4, 3, 1'b0, 4'b0000, 32'h0, 32'h200});
    vecs.push_back('{"lb_lane1", mk(OP_LOAD, F3_B), 32'h201, 32'h0, 32'h12807F34, 0,
                     1'b0, 32'h0000007F, 2, 1, 1'b0, 4'b0000, 32'h0, 32'h200});
    vecs.push_back('{"bad_opcode", mk(7'b0110011, F3_W), 32'h100, 32'h0, 32'h0, 0,
                     1'b1, 32'h0, 1, 0, 1'b0, 4'b0000, 32'h0, 32'h0});
    vecs.push_back('{"bad_load_f3", mk(OP_LOAD, 3'b011), 32'h100, 32'h0, 32'h0, 0,
                     1'b1, 32'h0, 1, 0, 1'b0, 4'b0000, 32'h0, 32'h0});
    vecs.push_back('{"sw_misalign", mk(OP_STORE, F3_W), 32'h102, 32'h0, 32'h0, 0,
                     1'b1, 32'h0, 1, 0, 1'b0, 4'b0000, 32'h0, 32'h0});
    vecs.push_back('{"bad_store_f3", mk(OP_STORE, F3_BU), 32'h100, 32'h0, 32'h0, 0,
                     1'b1, 32'h0, 1, 0, 1'b0, 4'b0000, 32'h0, 32'h0});
    vecs.push_back('{"sb_lane0", mk(OP_STORE, F3_B), 32'h0FC, 32'h0000003C, 32'h0, 1,
                     1'b0, 32'h0, 3, 2, 1'b1, 4'b0001, 32'h3C3C3C3C, 32'h0FC});

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst rdata", rdata, 32'h0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst mem_wmask", 32'(mem_wmask), 32'h0);
    chk("rst state", 32'(dbg_state), 32'(ST_IDLE));

    // mem_ready while idle must not produce any response
    mem_ready = 1'b1;
    saw_done = 1'b0;
    repeat (3) begin
      tick();
      if (done || mem_req || busy) saw_done = 1'b1;
    end
    mem_ready = 1'b0;
    chk("idle_ready ignored", 32'(saw_done), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      run_op(v);
    end

    // start during ACCESS is ignored; reset mid-ACCESS aborts without done
    @(negedge clk);
    start = 1'b1; inst = mk(OP_LOAD, F3_W); addr = 32'h300; wdata = '0;
    tick();
    inst = mk(OP_STORE, F3_W); addr = 32'h500;
    tick();
    start = 1'b0;
    chk("busy_start addr", mem_addr, 32'h300);
    chk("busy_start we", 32'(mem_we), 32'd0);
    chk("busy_start state", 32'(dbg_state), 32'(ST_ACCESS));
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("midrst mem_req", 32'(mem_req), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    cyc = 0;
    while (cyc < 6) begin
      tick();
      if (done || mem_req) saw_done = 1'b1;
      cyc++;
    end
    chk("midrst quiet", 32'(saw_done), 32'd0);

    v = '{"after_reset_lw", mk(OP_LOAD, F3_W), 32'h300, 32'h0, 32'h5A5A0001, 0,
          1'b0, 32'h5A5A0001, 2, 1, 1'b0, 4'b0000, 32'h0, 32'h300};
    run_op(v);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt + 1);
    $fatal(1);
  end

endmodule
